// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store misalignment splitter:
// RISC-V funct3 encodings and the sequencer state type.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/misalign_detect.sv
// Classifies an access by size and reports whether its address
// breaks natural alignment, plus how many bytes it spans.
module misalign_detect
    import lsu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lsb,
    output logic       misaligned,
    output logic [2:0] nbytes
);

    // funct3[1:0] encodes access size identically for loads and stores
    always_comb begin
        misaligned = 1'b0;
        nbytes     = 3'd1;
        case (funct3[1:0])
            F3_LH[1:0]: begin
                nbytes     = 3'd2;
                misaligned = addr_lsb[0];
            end
            F3_LW[1:0]: begin
                nbytes     = 3'd4;
                misaligned = |addr_lsb;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_splitter.sv
// Passes aligned accesses straight to datamemory; splits misaligned
// half/word accesses into byte accesses while stalling the pipeline.
module lsu_misalign_splitter
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam int NLANES = DATA_W / 8;
    localparam int IDX_W  = 2;

    lsu_state_t            state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [IDX_W-1:0]      last_idx_reg, last_idx;
    logic [DM_ADDRESS-1:0] lat_addr_reg;
    logic [DATA_W-1:0]     lat_wdata_reg;
    logic [2:0]            lat_funct3_reg;
    logic                  lat_read_reg;
    logic [7:0]            merge_reg [NLANES];
    logic [DATA_W-1:0]     merged;

    logic       misaligned;
    logic [2:0] nbytes;
    logic       start;

    misalign_detect u_detect (
        .funct3     (req_funct3),
        .addr_lsb   (req_addr[1:0]),
        .misaligned (misaligned),
        .nbytes     (nbytes)
    );

    assign start = (state_reg == IDLE) && (req_read || req_write) && misaligned;

    always_comb begin
        case (nbytes)
            3'd4:    last_idx = 2'd3;
            3'd2:    last_idx = 2'd1;
            default: last_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            last_idx_reg   <= '0;
            lat_addr_reg   <= '0;
            lat_wdata_reg  <= '0;
            lat_funct3_reg <= '0;
            lat_read_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (start) begin
                last_idx_reg   <= last_idx;
                lat_addr_reg   <= req_addr;
                lat_wdata_reg  <= req_wdata;
                lat_funct3_reg <= req_funct3;
                lat_read_reg   <= req_read;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (!reset || start) begin
                    merge_reg[gi] <= '0;
                end else if (state_reg == ISSUE && lat_read_reg && idx_reg == IDX_W'(gi)) begin
                    merge_reg[gi] <= mem_rd[7:0];
                end
            end
            assign merged[gi*8 +: 8] = merge_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;
        mem_funct3 = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    state_next = ISSUE;
                    idx_next   = '0;
                end else begin
                    // read wins when both strobes are raised
                    mem_read   = req_read;
                    mem_write  = req_write && !req_read;
                    mem_a      = req_addr;
                    mem_wd     = req_wdata;
                    mem_funct3 = req_funct3;
                    rsp_rdata  = mem_rd;
                    rsp_valid  = req_read;
                end
            end
            ISSUE: begin
                stall = 1'b1;
                mem_a = lat_addr_reg + DM_ADDRESS'(idx_reg);
                if (lat_read_reg) begin
                    mem_read   = 1'b1;
                    mem_funct3 = F3_LBU;
                end else begin
                    mem_write  = 1'b1;
                    mem_funct3 = F3_SB;
                    mem_wd     = DATA_W'(lat_wdata_reg[{idx_reg, 3'b000} +: 8]);
                end
                if (idx_reg == last_idx_reg) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = '0;
                if (lat_read_reg) begin
                    rsp_valid = 1'b1;
                    case (lat_funct3_reg)
                        F3_LH:   rsp_rdata = {{(DATA_W-16){merged[15]}}, merged[15:0]};
                        F3_LHU:  rsp_rdata = {{(DATA_W-16){1'b0}}, merged[15:0]};
                        default: rsp_rdata = merged;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset) begin
            stall      = 1'b0;
            rsp_valid  = 1'b0;
            rsp_rdata  = '0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_a      = '0;
            mem_wd     = '0;
            mem_funct3 = '0;
        end
    end

endmodule
